mem_responder: RTL

- Memory-side responder for the VeriRISC CPU bus.
- Answers the control unit's rd/wr/data_e strobes on a word-addressed single-port memory.
- Sits between the CPU address mux / data bus and on-chip storage: registered reads, one write per wr pulse, protocol-violation detection on the strobes.
- Replaces a passive RAM model so bus misuse is caught in hardware.

---
 rtl/mem_responder.sv | 107 ++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// VeriRISC memory-side responder: registered reads, one write per wr pulse,
// strobe misuse flagged in proto_err. Optional: MEM_RESPONDER_PARITY_EN.
module mem_responder #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] addr,
    input  logic              rd,
    input  logic              wr,
    input  logic              data_e,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              err_clr,
    output logic [DWIDTH-1:0] data_out,
    output logic              data_valid,
    output logic              proto_err,
    output logic              parity_err
);

`ifdef MEM_RESPONDER_PARITY_EN
    localparam int MW = DWIDTH + 1;
`else
    localparam int MW = DWIDTH;
`endif

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        WR_HOLD
    } state_t;

    state_t        state;
    logic          de_q;
    logic [MW-1:0] mem [2**AWIDTH];

    logic          in_wr;
    logic          first_wr;
    logic          do_rd;
    logic          do_wr;
    logic          conflict;
    logic          viol;
    logic [MW-1:0] wword;
    logic [MW-1:0] rword;

    // Decode the sampled strobes against the current write phase
    always_comb begin
        in_wr    = (state == WRITE) || (state == WR_HOLD);
        conflict = rd && wr;
        do_rd    = rd && !wr;
        first_wr = wr && !rd && !in_wr;
        do_wr    = first_wr && data_e;
        viol     = conflict || (first_wr && (!data_e || !de_q));
        rword    = mem[addr];
`ifdef MEM_RESPONDER_PARITY_EN
        wword    = {^data_in, data_in};
`else
        wword    = data_in;
`endif
    end

    // Storage array: no reset, only the first edge of a wr pulse writes
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[addr] <= wword;
        end
    end

    // Bus FSM with registered read data and sticky protocol flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            de_q       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            de_q       <= data_e;
            data_valid <= do_rd;
            proto_err  <= (proto_err && !err_clr) || viol;
            if (do_rd) begin
                data_out <= rword[DWIDTH-1:0];
            end
            unique case (1'b1)
                conflict:     state <= IDLE;
                do_rd:        state <= READ;
                (wr && !rd):  state <= (in_wr || !data_e) ? WR_HOLD : WRITE;
                default:      state <= IDLE;
            endcase
        end
    end

`ifdef MEM_RESPONDER_PARITY_EN
    // Sticky parity check on every read, rising with data_valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= (parity_err && !err_clr) || (do_rd && (^rword));
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
